// File: rtl/axi_lite_read_slave_if.sv
// AXI4-Lite read-address (AR) and read-data (R) channels between one master and one slave.
interface axi_lite_read_slave_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Handshake (both channels): a beat transfers on a rising edge where VALID and READY are
  // both high; once VALID rises it stays high with a stable payload until that edge.
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output ARADDR, ARVALID, RREADY,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  ARADDR, ARVALID, RREADY,
    output ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_read_slave.sv
// AXI4-Lite read slave: one outstanding read, alignment/range decode, register-port timeout.
module axi_lite_read_slave #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int TIMEOUT  = 15
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  axi_lite_read_slave_if.slave        bus,
  output logic                        reg_rd,
  output logic [$clog2(NUM_REGS)-1:0] reg_addr,
  input  logic [DATA_W-1:0]           reg_rdata,
  input  logic                        reg_ack,
  output logic [1:0]                  dbg_state
);
  localparam int IDX_W = $clog2(NUM_REGS);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W-1:0] ADDR_END = ADDR_W'(NUM_REGS * 4);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, FETCH = 2'd2, RESP = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [1:0]          err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                reg_rd_q, reg_rd_d;
  logic [IDX_W-1:0]    reg_addr_q, reg_addr_d;
  logic [1:0]          ar_decode;
  logic                ar_fire, r_fire, expired;

  // Handshakes use the registered READY/VALID so nothing is accepted in the cycle after reset.
  assign ar_fire = arready_q & bus.ARVALID;
  assign r_fire  = rvalid_q & bus.RREADY;
  assign expired = (cnt_q == CNT_LAST);

  // Decoding at AR acceptance lets reg_rd be a flop that is already high during ADDR.
  always_comb begin
    ar_decode = RESP_OKAY;
    if (bus.ARADDR[1:0] != 2'b00)   ar_decode = RESP_SLVERR;
    else if (bus.ARADDR >= ADDR_END) ar_decode = RESP_DECERR;
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q    <= IDLE;
      err_q      <= RESP_OKAY;
      cnt_q      <= '0;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
      reg_rd_q   <= 1'b0;
      reg_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      reg_rd_q   <= reg_rd_d;
      reg_addr_q <= reg_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_fire) state_d = ADDR;
      ADDR:    state_d = (err_q != RESP_OKAY) ? RESP : FETCH;
      FETCH:   if (reg_ack || expired) state_d = RESP;
      RESP:    if (r_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    err_d      = err_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    reg_addr_d = reg_addr_q;
    reg_rd_d   = 1'b0;
    arready_d  = (state_d == IDLE);
    rvalid_d   = (state_d == RESP);
    case (state_q)
      IDLE: begin
        if (ar_fire) begin
          err_d      = ar_decode;
          reg_addr_d = bus.ARADDR[IDX_W+1:2];
          reg_rd_d   = (ar_decode == RESP_OKAY);
        end
      end
      ADDR: begin
        cnt_d = '0;
        if (err_q != RESP_OKAY) begin
          rdata_d = '0;
          rresp_d = err_q;
        end
      end
      FETCH: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the expiry cycle still delivers data.
        if (reg_ack) begin
          rdata_d = reg_rdata;
          rresp_d = RESP_OKAY;
        end else if (expired) begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      end
      default: ;
    endcase
  end

  assign bus.ARREADY = arready_q;
  assign bus.RVALID  = rvalid_q;
  assign bus.RDATA   = rdata_q;
  assign bus.RRESP   = rresp_q;
  assign reg_rd      = reg_rd_q;
  assign reg_addr    = reg_addr_q;
  assign dbg_state   = state_q;
endmodule

// File: tb/tb_axi_lite_read_slave.sv
// Directed bench for axi_lite_read_slave: good reads, decode errors, timeout, backpressure, reset.
module tb_axi_lite_read_slave;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int TIMEOUT  = 15;
  localparam int IDX_W    = $clog2(NUM_REGS);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              reg_rd;
  logic [IDX_W-1:0]  reg_addr;
  logic [DATA_W-1:0] reg_rdata;
  logic              reg_ack;
  logic [1:0]        dbg_state;

  int n_tests = 0;
  int n_fail = 0;
  int rd_pulses = 0;
  logic [DATA_W+1:0] exp_q[$];

  axi_lite_read_slave_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  axi_lite_read_slave #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .TIMEOUT(TIMEOUT)
  ) dut (
    .ACLK      (clk),
    .ARESETn   (rst_n),
    .bus       (bus),
    .reg_rd    (reg_rd),
    .reg_addr  (reg_addr),
    .reg_rdata (reg_rdata),
    .reg_ack   (reg_ack),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every R handshake must match the oldest expected {RRESP, RDATA}.
  always @(negedge clk) begin
    if (rst_n && bus.RVALID && bus.RREADY) begin
      if (exp_q.size() == 0) check("r_unexpected", 64'd1, 64'd0);
      else                   check("r_beat", {bus.RRESP, bus.RDATA}, exp_q.pop_front());
    end
    if (reg_rd) rd_pulses++;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ar(input logic [ADDR_W-1:0] addr);
    check("arready_idle", bus.ARREADY, 1);
    bus.ARADDR  = addr;
    bus.ARVALID = 1'b1;
    tick();
    bus.ARVALID = 1'b0;
    check("arready_drop", bus.ARREADY, 0);
  endtask

  task automatic wait_rvalid(input int max_cycles, output int cycles);
    cycles = 0;
    while (!bus.RVALID && cycles < max_cycles) begin
      tick();
      cycles++;
    end
    if (!bus.RVALID) check("rvalid_wait_expired", 64'd0, 64'd1);
  endtask

  // Aligned in-range read with reg_ack 'delay' cycles after reg_rd; RREADY assumed high.
  task automatic read_ok(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] data,
                         input int delay);
    int p0;
    p0 = rd_pulses;
    exp_q.push_back({2'b00, data});
    do_ar(addr);
    check("rd_strobe", reg_rd, 1);
    check("rd_index", reg_addr, addr >> 2);
    for (int i = 0; i < delay; i++) begin
      check("rvalid_early", bus.RVALID, 0);
      tick();
    end
    reg_ack   = 1'b1;
    reg_rdata = data;
    tick();
    reg_ack   = 1'b0;
    reg_rdata = '0;
    check("ok_rvalid", bus.RVALID, 1);
    check("ok_rdata", bus.RDATA, data);
    check("ok_rresp", bus.RRESP, 2'b00);
    tick();
    check("ok_rvalid_drop", bus.RVALID, 0);
    check("ok_arready_back", bus.ARREADY, 1);
    check("ok_one_strobe", rd_pulses - p0, 1);
  endtask

  // Decode error: response two cycles after AR, no register access.
  task automatic read_err(input logic [ADDR_W-1:0] addr, input logic [1:0] resp);
    int p0;
    p0 = rd_pulses;
    exp_q.push_back({resp, {DATA_W{1'b0}}});
    do_ar(addr);
    check("err_no_strobe", reg_rd, 0);
    check("err_rvalid_early", bus.RVALID, 0);
    tick();
    check("err_rvalid", bus.RVALID, 1);
    check("err_rresp", bus.RRESP, resp);
    check("err_rdata", bus.RDATA, 0);
    tick();
    check("err_rvalid_drop", bus.RVALID, 0);
    check("err_arready_back", bus.ARREADY, 1);
    check("err_no_access", rd_pulses - p0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cyc;
    bus.ARADDR  = '0;
    bus.ARVALID = 1'b0;
    bus.RREADY  = 1'b0;
    reg_ack     = 1'b0;
    reg_rdata   = '0;

    #2;
    check("rst_arready", bus.ARREADY, 0);
    check("rst_rvalid", bus.RVALID, 0);
    check("rst_rdata", bus.RDATA, 0);
    check("rst_rresp", bus.RRESP, 0);
    check("rst_reg_rd", reg_rd, 0);
    check("rst_reg_addr", reg_addr, 0);
    check("rst_state", dbg_state, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rel_arready_low", bus.ARREADY, 0);
    tick();
    check("rel_arready", bus.ARREADY, 1);

    // Good reads; RREADY high before RVALID
    bus.RREADY = 1'b1;
    read_ok(32'h08, 32'hDEAD_BEEF, 1);
    read_ok(32'h3C, 32'h0F0F_1234, 3);

    // Decode errors: misalignment wins over range
    read_err(32'h06, 2'b10);
    read_err(32'h40, 2'b11);
    read_err(32'h41, 2'b10);
    read_err(32'h8000_0000, 2'b11);

    // Timeout without ack: RVALID 16 cycles after the ADDR cycle (15 FETCH cycles)
    exp_q.push_back({2'b10, {DATA_W{1'b0}}});
    do_ar(32'h0C);
    wait_rvalid(40, cyc);
    check("to_latency", cyc, 16);
    check("to_rresp", bus.RRESP, 2'b10);
    check("to_rdata", bus.RDATA, 0);
    tick();
    check("to_rvalid_drop", bus.RVALID, 0);

    // Ack in the expiry cycle wins
    read_ok(32'h10, 32'h1234_5678, 15);

    // Backpressure: 5 cycles of RREADY low
    bus.RREADY = 1'b0;
    exp_q.push_back({2'b00, 32'hA5A5_0014});
    do_ar(32'h14);
    tick();
    reg_ack   = 1'b1;
    reg_rdata = 32'hA5A5_0014;
    tick();
    reg_ack   = 1'b0;
    reg_rdata = '0;
    for (int i = 0; i < 5; i++) begin
      check("bp_rvalid", bus.RVALID, 1);
      check("bp_rdata", bus.RDATA, 32'hA5A5_0014);
      check("bp_rresp", bus.RRESP, 2'b00);
      check("bp_arready", bus.ARREADY, 0);
      tick();
    end
    check("bp_rvalid_held", bus.RVALID, 1);
    bus.RREADY = 1'b1;
    tick();
    check("bp_rvalid_drop", bus.RVALID, 0);
    check("bp_arready_back", bus.ARREADY, 1);

    // Back-to-back with ARVALID held high
    exp_q.push_back({2'b00, 32'h1111_0000});
    exp_q.push_back({2'b00, 32'h2222_0004});
    check("b2b_arready", bus.ARREADY, 1);
    bus.ARADDR  = 32'h00;
    bus.ARVALID = 1'b1;
    tick();
    check("b2b_rd0", reg_rd, 1);
    check("b2b_idx0", reg_addr, 0);
    bus.ARADDR = 32'h04;
    tick();
    reg_ack   = 1'b1;
    reg_rdata = 32'h1111_0000;
    tick();
    reg_ack   = 1'b0;
    check("b2b_rvalid0", bus.RVALID, 1);
    check("b2b_arready_resp", bus.ARREADY, 0);
    tick();
    check("b2b_rvalid0_drop", bus.RVALID, 0);
    check("b2b_arready_again", bus.ARREADY, 1);
    check("b2b_no_early_rd", reg_rd, 0);
    tick();
    bus.ARVALID = 1'b0;
    check("b2b_ar1_taken", bus.ARREADY, 0);
    check("b2b_rd1", reg_rd, 1);
    check("b2b_idx1", reg_addr, 1);
    tick();
    reg_ack   = 1'b1;
    reg_rdata = 32'h2222_0004;
    tick();
    reg_ack   = 1'b0;
    reg_rdata = '0;
    check("b2b_rvalid1", bus.RVALID, 1);
    tick();
    check("b2b_rvalid1_drop", bus.RVALID, 0);

    // Reset while waiting in FETCH
    do_ar(32'h18);
    tick();
    tick();
    check("mid_state_fetch", dbg_state, 2);
    rst_n = 1'b0;
    #1;
    check("mid_arready", bus.ARREADY, 0);
    check("mid_rvalid", bus.RVALID, 0);
    check("mid_rdata", bus.RDATA, 0);
    check("mid_rresp", bus.RRESP, 0);
    check("mid_reg_rd", reg_rd, 0);
    check("mid_reg_addr", reg_addr, 0);
    check("mid_state", dbg_state, 0);
    tick();
    rst_n     = 1'b1;
    reg_ack   = 1'b1;
    reg_rdata = 32'h0000_0BAD;
    check("mid_rel_arready_low", bus.ARREADY, 0);
    tick();
    reg_ack = 1'b0;
    check("mid_rel_arready", bus.ARREADY, 1);
    check("mid_rel_state", dbg_state, 0);
    for (int i = 0; i < 3; i++) begin
      check("mid_no_rvalid", bus.RVALID, 0);
      tick();
    end

    // ---------------- report ----------------
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
